// File: rtl/cpu_pkg.sv
// Shared encodings between the register datapath and the control unit:
// bus-source select codes and the bit positions inside the strobe vectors.
package cpu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    SRC_NONE = 4'd0,
    SRC_PC   = 4'd1,
    SRC_AR   = 4'd2,
    SRC_IR   = 4'd4,
    SRC_AC   = 4'd5,
    SRC_R    = 4'd6,
    SRC_R1   = 4'd7,
    SRC_R2   = 4'd8,
    SRC_R3   = 4'd9,
    SRC_R4   = 4'd10,
    SRC_DM   = 4'd12,
    SRC_IM   = 4'd13,
    SRC_AC2  = 4'd14
  } src_e;

  // write_en bit positions
  localparam int WE_PC     = 1;
  localparam int WE_AR     = 2;
  localparam int WE_IR     = 3;
  localparam int WE_AC     = 4;
  localparam int WE_R      = 5;
  localparam int WE_R4     = 7;
  localparam int WE_R3     = 8;
  localparam int WE_R2     = 9;
  localparam int WE_R1     = 10;
  localparam int WE_DM     = 11;
  localparam int WE_AC_ALU = 12;

  // inc_en / clr_en bit positions
  localparam int INC_PC = 1;
  localparam int INC_AC = 4;
  localparam int CLR_PC = 1;
  localparam int CLR_AR = 2;
  localparam int CLR_AC = 4;

endpackage

// File: rtl/datapath_regs_if.sv
// Control/memory-facing signal bundle of the register datapath.
// master = control unit and memories, slave = the datapath itself.
interface datapath_regs_if;
  logic [3:0]  read_en;
  logic [15:0] write_en;
  logic [15:0] inc_en;
  logic [15:0] clr_en;
  logic [15:0] alu_result;
  logic [15:0] ac_q;
  logic [15:0] r_q;
  logic [15:0] im_addr;
  logic [15:0] im_rdata;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_we;
  logic [15:0] dm_rdata;
  logic [4:0]  instruction;
  logic        z;

  modport master (
    output read_en, write_en, inc_en, clr_en, alu_result, im_rdata, dm_rdata,
    input  ac_q, r_q, im_addr, dm_addr, dm_wdata, dm_we, instruction, z
  );

  modport slave (
    input  read_en, write_en, inc_en, clr_en, alu_result, im_rdata, dm_rdata,
    output ac_q, r_q, im_addr, dm_addr, dm_wdata, dm_we, instruction, z
  );
endinterface

// File: rtl/datapath_regs_reg16.sv
// One 16-bit datapath register: clear beats load beats increment beats hold.
module reg16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic        inc,
  input  logic [15:0] d,
  output logic [15:0] q
);

  logic [15:0] q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q_reg <= 16'h0000;
    else if (clr)  q_reg <= 16'h0000;
    else if (load) q_reg <= d;
    else if (inc)  q_reg <= q_reg + 16'd1;
  end

  assign q = q_reg;

endmodule

// File: rtl/datapath_regs.sv
// Register file of the accumulator CPU around a single shared 16-bit bus.
// Every register samples the bus value present before the edge, so self-loads are safe.
module datapath_regs
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  datapath_regs_if.slave   bus_if
);

  logic [15:0] bus;
  logic [15:0] pc_q, ar_q, ir_q, ac_q, r_q;
  logic [15:0] gp_q [4];   // R1..R4
  logic [15:0] ac_d;
  logic        ac_load;

  always_comb begin
    bus = 16'h0000;
    case (src_e'(bus_if.read_en))
      SRC_PC:  bus = pc_q;
      SRC_AR:  bus = ar_q;
      SRC_IR:  bus = {5'b0, ir_q[15:5]};
      SRC_AC:  bus = ac_q;
      SRC_R:   bus = r_q;
      SRC_R1:  bus = gp_q[0];
      SRC_R2:  bus = gp_q[1];
      SRC_R3:  bus = gp_q[2];
      SRC_R4:  bus = gp_q[3];
      SRC_DM:  bus = bus_if.dm_rdata;
      SRC_IM:  bus = bus_if.im_rdata;
      SRC_AC2: bus = ac_q;
      default: bus = 16'h0000;
    endcase
  end

  // A bus load into AC outranks the ALU write-back when both strobe together.
  assign ac_load = bus_if.write_en[WE_AC] | bus_if.write_en[WE_AC_ALU];
  assign ac_d    = bus_if.write_en[WE_AC] ? bus : bus_if.alu_result;

  reg16 u_pc (.clk(clk), .rst(rst), .clr(bus_if.clr_en[CLR_PC]), .load(bus_if.write_en[WE_PC]),
              .inc(bus_if.inc_en[INC_PC]), .d(bus), .q(pc_q));
  reg16 u_ar (.clk(clk), .rst(rst), .clr(bus_if.clr_en[CLR_AR]), .load(bus_if.write_en[WE_AR]),
              .inc(1'b0), .d(bus), .q(ar_q));
  reg16 u_ir (.clk(clk), .rst(rst), .clr(1'b0), .load(bus_if.write_en[WE_IR]),
              .inc(1'b0), .d(bus), .q(ir_q));
  reg16 u_ac (.clk(clk), .rst(rst), .clr(bus_if.clr_en[CLR_AC]), .load(ac_load),
              .inc(bus_if.inc_en[INC_AC]), .d(ac_d), .q(ac_q));
  reg16 u_r  (.clk(clk), .rst(rst), .clr(1'b0), .load(bus_if.write_en[WE_R]),
              .inc(1'b0), .d(bus), .q(r_q));

  // R1..R4 sit on descending write_en bits 10..7.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_gp
      reg16 u_gp (.clk(clk), .rst(rst), .clr(1'b0), .load(bus_if.write_en[WE_R1 - gi]),
                  .inc(1'b0), .d(bus), .q(gp_q[gi]));
    end
  endgenerate

  assign bus_if.ac_q        = ac_q;
  assign bus_if.r_q         = r_q;
  assign bus_if.im_addr     = pc_q;
  assign bus_if.dm_addr     = ar_q;
  assign bus_if.dm_wdata    = bus;
  assign bus_if.dm_we       = bus_if.write_en[WE_DM];
  assign bus_if.instruction = ir_q[4:0];
  assign bus_if.z           = (ac_q == 16'h0000);

  logic unused_strobes;
  assign unused_strobes = ^{bus_if.write_en[0], bus_if.write_en[6], bus_if.write_en[15:13],
                            bus_if.inc_en[15:5], bus_if.inc_en[3:2], bus_if.inc_en[0],
                            bus_if.clr_en[15:5], bus_if.clr_en[3], bus_if.clr_en[0]};

endmodule

// File: tb/tb_datapath_regs.sv
// Directed-vector bench for datapath_regs: reset, fetch, priority, wrap, store,
// address path and simultaneous multi-destination loads.
module tb_datapath_regs;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  datapath_regs_if dp ();

  datapath_regs dut (.clk(clk), .rst(rst), .bus_if(dp));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dp.read_en    = 4'd0;
    dp.write_en   = 16'h0;
    dp.inc_en     = 16'h0;
    dp.clr_en     = 16'h0;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Load a register from the bus using dm_rdata as source.
  task automatic load(input int bit_idx, input logic [15:0] val);
    idle();
    dp.dm_rdata = val;
    dp.read_en  = 4'd12;
    dp.write_en[bit_idx] = 1'b1;
    step();
    idle();
  endtask

  task automatic peek(input logic [3:0] code, input string name, input logic [15:0] exp);
    dp.read_en = code;
    #1;
    chk(name, dp.dm_wdata, exp);
    dp.read_en = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    dp.alu_result = 16'h0;
    dp.im_rdata   = 16'h0;
    dp.dm_rdata   = 16'h0;
    #12;
    chk("rst_im_addr", dp.im_addr, 16'h0);
    chk("rst_dm_addr", dp.dm_addr, 16'h0);
    chk("rst_instruction", {11'b0, dp.instruction}, 16'h0);
    chk("rst_z", {15'b0, dp.z}, 16'h1);
    chk("rst_ac", dp.ac_q, 16'h0);
    chk("rst_r", dp.r_q, 16'h0);
    rst = 1'b0;
    load(4, 16'h1234);
    load(5, 16'h5555);
    load(1, 16'h0042);
    chk("pre_async_ac", dp.ac_q, 16'h1234);
    chk("pre_async_z", {15'b0, dp.z}, 16'h0);
    #2 rst = 1'b1;
    #1;
    chk("async_ac", dp.ac_q, 16'h0);
    chk("async_z", {15'b0, dp.z}, 16'h1);
    chk("async_r", dp.r_q, 16'h0);
    chk("async_pc", dp.im_addr, 16'h0);
    #1 rst = 1'b0;
  endtask

  task automatic test_fetch();
    load(1, 16'h0003);
    dp.im_rdata = 16'h00A7;
    dp.read_en  = 4'd13;
    dp.write_en[3] = 1'b1;
    #1;
    chk("fetch_im_addr", dp.im_addr, 16'h0003);
    step();
    idle();
    chk("fetch_instruction", {11'b0, dp.instruction}, 16'h0007);
    peek(4'd4, "fetch_ir_field", 16'h0005);
    dp.inc_en[1] = 1'b1;
    step();
    idle();
    chk("fetch_pc_inc", dp.im_addr, 16'h0004);
  endtask

  task automatic test_priority();
    load(4, 16'h0005);
    dp.dm_rdata = 16'h0099;
    dp.read_en  = 4'd12;
    dp.clr_en[4] = 1'b1; dp.write_en[4] = 1'b1; dp.inc_en[4] = 1'b1;
    step();
    idle();
    chk("prio_clr", dp.ac_q, 16'h0000);
    dp.dm_rdata = 16'h0011;
    dp.read_en  = 4'd12;
    dp.alu_result = 16'h0022;
    dp.write_en[4] = 1'b1; dp.write_en[12] = 1'b1; dp.inc_en[4] = 1'b1;
    step();
    idle();
    chk("prio_bus_over_alu", dp.ac_q, 16'h0011);
    dp.write_en[12] = 1'b1; dp.inc_en[4] = 1'b1;
    step();
    idle();
    chk("prio_alu_over_inc", dp.ac_q, 16'h0022);
    dp.inc_en[4] = 1'b1;
    step();
    idle();
    chk("ac_inc", dp.ac_q, 16'h0023);
  endtask

  task automatic test_wrap();
    load(4, 16'hFFFF);
    chk("wrap_z_before", {15'b0, dp.z}, 16'h0);
    dp.inc_en[4] = 1'b1;
    step();
    idle();
    chk("wrap_ac", dp.ac_q, 16'h0000);
    chk("wrap_z", {15'b0, dp.z}, 16'h1);
    load(1, 16'hFFFF);
    dp.inc_en[1] = 1'b1;
    step();
    idle();
    chk("wrap_pc", dp.im_addr, 16'h0000);
  endtask

  task automatic test_store();
    load(2, 16'h0020);
    load(4, 16'hBEEF);
    dp.read_en = 4'd5;
    dp.write_en[11] = 1'b1;
    #1;
    chk("store_we", {15'b0, dp.dm_we}, 16'h1);
    chk("store_addr", dp.dm_addr, 16'h0020);
    chk("store_wdata", dp.dm_wdata, 16'hBEEF);
    step();
    idle();
    #1;
    chk("store_we_drop", {15'b0, dp.dm_we}, 16'h0);
    chk("store_ac_kept", dp.ac_q, 16'hBEEF);
  endtask

  task automatic test_addr_path();
    load(3, 16'h0C45);
    chk("addr_instruction", {11'b0, dp.instruction}, 16'h0005);
    dp.read_en = 4'd4;
    dp.write_en[2] = 1'b1;
    step();
    idle();
    chk("addr_ar", dp.dm_addr, 16'h0062);
    load(10, 16'h1111);
    peek(4'd7, "r1_loaded", 16'h1111);
    dp.read_en = 4'd11;
    dp.write_en[10] = 1'b1;
    step();
    idle();
    peek(4'd7, "r1_illegal_src", 16'h0000);
    peek(4'd15, "src15_zero", 16'h0000);
  endtask

  task automatic test_back_to_back();
    dp.dm_rdata = 16'hABCD;
    dp.read_en  = 4'd12;
    dp.write_en = 16'h0;
    dp.write_en[2] = 1'b1; dp.write_en[5] = 1'b1; dp.write_en[7] = 1'b1;
    dp.write_en[8] = 1'b1; dp.write_en[9] = 1'b1; dp.write_en[10] = 1'b1;
    step();
    idle();
    chk("multi_r", dp.r_q, 16'hABCD);
    chk("multi_ar", dp.dm_addr, 16'hABCD);
    peek(4'd7,  "multi_r1", 16'hABCD);
    peek(4'd8,  "multi_r2", 16'hABCD);
    peek(4'd9,  "multi_r3", 16'hABCD);
    peek(4'd10, "multi_r4", 16'hABCD);
    load(4, 16'h1357);
    dp.read_en = 4'd5;
    dp.write_en[4] = 1'b1; dp.write_en[5] = 1'b1;
    step();
    idle();
    chk("self_ac", dp.ac_q, 16'h1357);
    chk("self_r", dp.r_q, 16'h1357);
    peek(4'd14, "src14_ac", 16'h1357);
    load(1, 16'h0100);
    dp.read_en = 4'd1;
    dp.write_en[1] = 1'b1; dp.inc_en[1] = 1'b1;
    step();
    idle();
    chk("self_pc_load_over_inc", dp.im_addr, 16'h0100);
    dp.clr_en[1] = 1'b1; dp.clr_en[2] = 1'b1;
    step();
    idle();
    chk("clr_pc", dp.im_addr, 16'h0000);
    chk("clr_ar", dp.dm_addr, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_wrap();
    test_store();
    test_addr_path();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/datapath_regs.md
DATAPATH_REGS -- requirements
Module: datapath_regs

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising-edge active; one clock, reset is asynchronous and active-high.
REQ-002 SHALL have: rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have: read_en  in  4  bus-source select code from control.
REQ-004 SHALL have: write_en  in  16  per-destination load strobes (bit map in REQ-012).
REQ-005 SHALL have: inc_en  in  16  increment strobes; bit1 PC, bit4 AC, all other bits ignored.
REQ-006 SHALL have: clr_en  in  16  clear strobes; bit1 PC, bit2 AR, bit4 AC, all other bits ignored.
REQ-007 SHALL have: alu_result  in  16  ALU output; ac_q  out  16  AC value; r_q  out  16  R value (both ALU operands).
REQ-008 SHALL have: im_addr  out  16  = PC; im_rdata  in  16  instruction memory read data (combinational).
REQ-009 SHALL have: dm_addr  out  16  = AR; dm_wdata  out  16  = bus; dm_we  out  1  = write_en[11]; dm_rdata  in  16.
REQ-010 SHALL have: instruction  out  5  = IR[4:0]; z  out  1  high when AC == 16'h0000.

Function
REQ-011 SHALL drive a 16-bit bus combinationally from read_en: 0 -> 0; 1 PC; 2 AR; 4 {5'b0, IR[15:5]}; 5 AC; 6 R; 7 R1; 8 R2; 9 R3; 10 R4; 12 dm_rdata; 13 im_rdata; 14 AC; codes 3, 11, 15 -> 0.
REQ-012 SHALL map write_en: bit1 PC, bit2 AR, bit3 IR, bit4 AC (from bus), bit5 R, bit7 R4, bit8 R3, bit9 R2, bit10 R1, bit11 DM, bit12 AC (from alu_result); bits 0, 6, 13-15 ignored.
REQ-013 SHALL update every register only on rising clk; loads take bus value present in the same cycle (1-cycle latency, result visible next cycle).
REQ-014 SHALL apply per-register priority clr > write (bus) > write (alu, AC only) > inc > hold.
REQ-015 SHALL increment PC and AC modulo 2^16 (FFFF + 1 -> 0000, no carry output).
REQ-016 SHALL allow any number of different destinations to load from the bus in the same cycle.
REQ-017 SHALL allow a register to be both bus source and destination in one cycle; it loads the pre-edge value (no combinational loop).
REQ-018 SHALL compute z combinationally from the registered AC; z changes only after an AC-modifying edge.
REQ-019 SHALL NOT gate dm_we with anything but write_en[11]; DM write occurs on the same edge as the strobe.

Reset
REQ-020 SHALL, on rst high, clear PC, AR, IR, AC, R, R1-R4 to 16'h0000 immediately, regardless of clk.
REQ-021 SHALL hold all registers at zero while rst is high; outputs: im_addr 0, dm_addr 0, instruction 0, z 1, ac_q 0, r_q 0.
REQ-022 SHALL resume normal updates on the first rising clk after rst deasserts; a reset mid-instruction discards all partial state.

Structure
REQ-023 SHALL place read_en code constants and write/inc/clr bit-index constants in shared package cpu_pkg, used also by control.
REQ-024 SHALL build each register from one sub-module reg16 (clr, load, inc, d; priority per REQ-014); PC, AC instantiate with inc, others with inc tied low.

Verification
REQ-025 Reset: rst pulse mid-cycle with AC=1234 -> all regs 0000 asynchronously, z=1.
REQ-026 Fetch: PC=0003, im_rdata=00A7, read_en=13, write_en[3] -> IR=00A7, instruction=07; next cycle inc_en[1] -> PC=0004.
REQ-027 Priority: AC=0005, clr_en[4]+write_en[4]+inc_en[4] same cycle -> AC=0000; write_en[4]+write_en[12] with bus=0011, alu_result=0022 -> AC=0011.
REQ-028 Wrap: AC=FFFF, inc_en[4] -> AC=0000, z=1; PC=FFFF, inc_en[1] -> PC=0000.
REQ-029 Store: AR=0020, AC=BEEF, read_en=5, write_en[11] -> dm_we=1, dm_addr=0020, dm_wdata=BEEF for that cycle only.
REQ-030 Address path: IR=0x0C45 (addr field 0x062), read_en=4, write_en[2] -> AR=0062; illegal read_en=11 with write_en[10] -> R1=0000.
